// File: rtl/execute_stage_vec.sv
// Vector execute stage plus EX/MEM pipeline register.
// Each lane has its own ALU. Immediates can go to lane 0 only or to every lane.
// MUL takes MUL_LAT cycles. While it runs, stall_e holds the upstream stages.
module execute_stage_vec #(
    parameter int LANES   = 4,
    parameter int LANE_W  = 32,
    parameter int REG_AW  = 6,
    parameter int PC_W    = 32,
    parameter int MUL_LAT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_e,
    input  logic                  flush_e,
    input  logic                  RegWriteE,
    input  logic                  MemWriteE,
    input  logic                  ResultSrcE,
    input  logic                  ALUSrcE,
    input  logic                  BranchE,
    input  logic                  is_vectorial,
    input  logic [2:0]            ALUControlE,
    input  logic [LANES*LANE_W-1:0] RD1_E,
    input  logic [LANES*LANE_W-1:0] RD2_E,
    input  logic [31:0]           Imm_Ext_E,
    input  logic [REG_AW-1:0]     RD_E,
    input  logic [PC_W-1:0]       PCE,
    input  logic [PC_W-1:0]       PCPlus4E,
    input  logic [LANES*LANE_W-1:0] ResultW,
    input  logic [1:0]            ForwardA_E,
    input  logic [1:0]            ForwardB_E,
    output logic                  stall_e,
    output logic                  PCSrcE,
    output logic [PC_W-1:0]       PCTargetE,
    output logic                  valid_m,
    output logic                  RegWriteM,
    output logic                  MemWriteM,
    output logic                  ResultSrcM,
    output logic [REG_AW-1:0]     RD_M,
    output logic [PC_W-1:0]       PCPlus4M,
    output logic [LANES*LANE_W-1:0] WriteDataM,
    output logic [LANES*LANE_W-1:0] ALU_ResultM
);
    localparam int W     = LANES * LANE_W;
    localparam int SH_W  = $clog2(LANE_W);
    localparam int IMM_W = (LANE_W > 32) ? LANE_W : 32;
    localparam int CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (MUL_LAT > 1) ? CNT_W'(MUL_LAT - 2) : '0;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
        OP_XOR = 3'b100, OP_SLT = 3'b101, OP_SLL = 3'b110, OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic {S_IDLE, S_MUL} state_e;

    state_e            r_state, w_state_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic              w_mul_load;

    // Operands and controls captured when a multi-cycle MUL starts.
    logic [W-1:0]      r_mul_a, r_mul_b, r_mul_wd;
    logic              r_mul_vec, r_mul_rw, r_mul_mw, r_mul_rs;
    logic [REG_AW-1:0] r_mul_rd;
    logic [PC_W-1:0]   r_mul_pc4;

    logic [W-1:0]      w_src_a, w_src_bi, w_src_b, w_imm_vec;
    logic [IMM_W-1:0]  w_imm_sx;
    logic [LANE_W-1:0] w_imm_lane;
    logic              w_unused_imm;
    logic [W-1:0]      w_op_a, w_op_b, w_result;
    alu_op_e           w_op;
    logic              w_vec, w_zero, w_start, w_in_mul, w_bubble;

    function automatic logic [LANE_W-1:0] lane_alu(input alu_op_e op,
                                                   input logic [LANE_W-1:0] a,
                                                   input logic [LANE_W-1:0] b);
        logic [LANE_W-1:0] y;
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SLT:  y = ($signed(a) < $signed(b)) ? LANE_W'(1) : '0;
            OP_SLL:  y = a << b[SH_W-1:0];
            OP_MUL:  y = a * b;
            default: y = '0;
        endcase
        return y;
    endfunction

    // Forwarding muxes for both register operands.
    always_comb begin
        case (ForwardA_E)
            2'b01:   w_src_a = ResultW;
            2'b10:   w_src_a = ALU_ResultM;
            default: w_src_a = RD1_E;
        endcase
        case (ForwardB_E)
            2'b01:   w_src_bi = ResultW;
            2'b10:   w_src_bi = ALU_ResultM;
            default: w_src_bi = RD2_E;
        endcase
    end

    assign w_imm_sx     = IMM_W'($signed(Imm_Ext_E));
    assign w_imm_lane   = w_imm_sx[LANE_W-1:0];
    assign w_unused_imm = ^w_imm_sx;

    // Put the immediate in lane 0, or in every lane for a vector op.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_imm_vec = '0;
        for (int l = 0; l < LANES; l++) begin
            if (l == 0 || is_vectorial) w_imm_vec[l*LANE_W +: LANE_W] = w_imm_lane;
        end
    end

    assign w_src_b  = ALUSrcE ? w_imm_vec : w_src_bi;

    // While a MUL is running, the ALU reads the latched operands, not the live inputs.
    assign w_in_mul = (r_state == S_MUL);
    assign w_op_a   = w_in_mul ? r_mul_a   : w_src_a;
    assign w_op_b   = w_in_mul ? r_mul_b   : w_src_b;
    assign w_vec    = w_in_mul ? r_mul_vec : is_vectorial;
    assign w_op     = w_in_mul ? OP_MUL    : alu_op_e'(ALUControlE);

    // Per-lane ALU. Upper lanes are zero for scalar ops.
    always_comb begin
        w_result = '0;
        for (int l = 0; l < LANES; l++) begin
            if (l == 0 || w_vec)
                w_result[l*LANE_W +: LANE_W] = lane_alu(w_op, w_op_a[l*LANE_W +: LANE_W],
                                                        w_op_b[l*LANE_W +: LANE_W]);
        end
    end

    assign w_zero    = (w_result == '0);
    assign PCSrcE    = valid_e & BranchE & w_zero & ~stall_e & ~flush_e;
    assign PCTargetE = PCE + PC_W'($signed(Imm_Ext_E));

    assign w_start   = valid_e & ~flush_e & (ALUControlE == OP_MUL) & (MUL_LAT > 1);

    // MUL FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // MUL FSM next state, counter and stall.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        stall_e      = 1'b0;
        w_mul_load   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_mul_load   = 1'b1;
                    stall_e      = 1'b1;
                    w_cnt_next   = CNT_INIT;
                    w_state_next = S_MUL;
                end
            end
            S_MUL: begin
                stall_e = (r_cnt != '0);
                if (flush_e) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt != '0) begin
                    w_cnt_next   = r_cnt - 1'b1;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Latch MUL operands and controls on the cycle the op starts.
    always_ff @(posedge clk) begin
        // NOTE: these registers have no reset. They are read only in S_MUL, and S_MUL is always entered through a load.
        if (w_mul_load) begin
            r_mul_a   <= w_src_a;
            r_mul_b   <= w_src_b;
            r_mul_wd  <= w_src_bi;
            r_mul_vec <= is_vectorial;
            r_mul_rw  <= RegWriteE;
            r_mul_mw  <= MemWriteE;
            r_mul_rs  <= ResultSrcE;
            r_mul_rd  <= RD_E;
            r_mul_pc4 <= PCPlus4E;
        end
    end

    assign w_bubble = stall_e | flush_e | ~valid_e;

    // EX/MEM register. A bubble clears the controls and keeps the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_m     <= 1'b0;
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= 1'b0;
            RD_M        <= '0;
            PCPlus4M    <= '0;
            WriteDataM  <= '0;
            ALU_ResultM <= '0;
        end else if (w_bubble) begin
            valid_m     <= 1'b0;
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= 1'b0;
        end else begin
            valid_m     <= 1'b1;
            RegWriteM   <= w_in_mul ? r_mul_rw  : RegWriteE;
            MemWriteM   <= w_in_mul ? r_mul_mw  : MemWriteE;
            ResultSrcM  <= w_in_mul ? r_mul_rs  : ResultSrcE;
            RD_M        <= w_in_mul ? r_mul_rd  : RD_E;
            PCPlus4M    <= w_in_mul ? r_mul_pc4 : PCPlus4E;
            WriteDataM  <= w_in_mul ? r_mul_wd  : w_src_bi;
            ALU_ResultM <= w_result;
        end
    end
endmodule

// File: tb/tb_execute_stage_vec.sv
// Scoreboard bench for execute_stage_vec with the default parameters (4 x 32-bit lanes, MUL_LAT=4).
module tb_execute_stage_vec;
    localparam int W = 128;

    logic          clk = 1'b0;
    logic          rst, valid_e, flush_e;
    logic          RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, is_vectorial;
    logic [2:0]    ALUControlE;
    logic [W-1:0]  RD1_E, RD2_E, ResultW;
    logic [31:0]   Imm_Ext_E, PCE, PCPlus4E;
    logic [5:0]    RD_E;
    logic [1:0]    ForwardA_E, ForwardB_E;
    logic          stall_e, PCSrcE;
    logic [31:0]   PCTargetE, PCPlus4M;
    logic          valid_m, RegWriteM, MemWriteM, ResultSrcM;
    logic [5:0]    RD_M;
    logic [W-1:0]  WriteDataM, ALU_ResultM;

    typedef struct {
        int           id;
        logic [W-1:0] alu;
        logic [W-1:0] wd;
        logic [5:0]   rd;
        logic [31:0]  pc4;
        logic [2:0]   ctrl;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_pass = 0;
    int   n_total = 0;
    int   n_issue = 0;

    execute_stage_vec dut (
        .clk(clk), .rst(rst), .valid_e(valid_e), .flush_e(flush_e),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .ALUSrcE(ALUSrcE), .BranchE(BranchE), .is_vectorial(is_vectorial),
        .ALUControlE(ALUControlE), .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
        .RD_E(RD_E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ResultW(ResultW),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .stall_e(stall_e), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .valid_m(valid_m), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
        .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at 200000, expected $finish earlier");
        $fatal(1, "timeout");
    end

    function automatic logic [W-1:0] v4(input logic [31:0] l3, input logic [31:0] l2,
                                        input logic [31:0] l1, input logic [31:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_e = 0; flush_e = 0; RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0;
        ALUSrcE = 0; BranchE = 0; is_vectorial = 0; ALUControlE = 3'b000;
        RD1_E = '0; RD2_E = '0; ResultW = '0; Imm_Ext_E = '0; RD_E = '0;
        PCE = '0; PCPlus4E = '0; ForwardA_E = 2'b00; ForwardB_E = 2'b00;
    endtask

    // Drive one valid instruction and push the M-stage result it should produce.
    task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic vec, input logic alusrc, input logic [31:0] imm,
                         input logic [W-1:0] exp_alu, input logic [W-1:0] exp_wd);
        exp_t e;
        valid_e = 1; flush_e = 0; ALUControlE = op; RD1_E = a; RD2_E = b;
        is_vectorial = vec; ALUSrcE = alusrc; Imm_Ext_E = imm;
        RegWriteE = 1; MemWriteE = n_issue[0]; ResultSrcE = n_issue[1];
        RD_E = 6'(n_issue + 1); PCPlus4E = 32'h1000 + 32'(n_issue * 4);
        e.id = n_issue; e.alu = exp_alu; e.wd = exp_wd; e.rd = RD_E; e.pc4 = PCPlus4E;
        e.ctrl = {1'b1, MemWriteE, ResultSrcE};
        sb.push_back(e);
        n_issue++;
    endtask

    task automatic check_m_zero(input string tag);
        check({tag, "_valid_m"}, valid_m, 0);
        check({tag, "_ctrl"}, {RegWriteM, MemWriteM, ResultSrcM}, 0);
        check({tag, "_rd_m"}, RD_M, 0);
        check({tag, "_pc4_m"}, PCPlus4M, 0);
        check({tag, "_wd_m"}, WriteDataM, 0);
        check({tag, "_alu_m"}, ALU_ResultM, 0);
        check({tag, "_stall"}, stall_e, 0);
    endtask

    // Monitor: each valid M output is compared with the oldest expected entry.
    initial begin
        forever begin
            @(negedge clk);
            if (valid_m === 1'b1) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_output: valid_m=1 with alu=%h, expected no output", ALU_ResultM);
                end else begin
                    mon_e = sb.pop_front();
                    check($sformatf("i%0d_alu", mon_e.id), ALU_ResultM, mon_e.alu);
                    check($sformatf("i%0d_wd", mon_e.id), WriteDataM, mon_e.wd);
                    check($sformatf("i%0d_rd", mon_e.id), RD_M, mon_e.rd);
                    check($sformatf("i%0d_pc4", mon_e.id), PCPlus4M, mon_e.pc4);
                    check($sformatf("i%0d_ctrl", mon_e.id), {RegWriteM, MemWriteM, ResultSrcM}, mon_e.ctrl);
                end
            end
        end
    end

    logic [2:0]   t_op [6];
    logic [W-1:0] t_exp[6];
    logic [W-1:0] ta, tb;
    int           n;

    initial begin
        idle_inputs();
        rst = 1;
        tick(); tick();
        check_m_zero("reset");
        check("reset_pcsrc", PCSrcE, 0);
        rst = 0;

        // Vector ADD.
        drive(3'b000, v4(4, 3, 2, 1), v4(40, 30, 20, 10), 1, 0, 0,
              v4(44, 33, 22, 11), v4(40, 30, 20, 10));
        #1 check("add_stall", stall_e, 0);
        tick();

        // Immediate: lane 0 only for scalar, every lane for vector.
        drive(3'b000, v4(100, 200, 300, 7), v4(9, 9, 9, 9), 0, 1, 5,
              v4(0, 0, 0, 12), v4(9, 9, 9, 9));
        tick();
        drive(3'b000, v4(100, 200, 300, 7), v4(9, 9, 9, 9), 1, 1, 5,
              v4(105, 205, 305, 12), v4(9, 9, 9, 9));
        tick();

        // Remaining single-cycle ops on one operand set.
        ta = v4(32'h8000_0000, 32'hF0F0_F0F0, 32'h40, 32'hFFFF_FFFF);
        tb = v4(32'h1, 32'h0FF0_0FF0, 32'h23, 32'h3);
        t_op[0] = 3'b001; t_exp[0] = v4(32'h7FFF_FFFF, 32'hE100_E100, 32'h1D, 32'hFFFF_FFFC);
        t_op[1] = 3'b010; t_exp[1] = v4(32'h0, 32'h00F0_00F0, 32'h0, 32'h3);
        t_op[2] = 3'b011; t_exp[2] = v4(32'h8000_0001, 32'hFFF0_FFF0, 32'h63, 32'hFFFF_FFFF);
        t_op[3] = 3'b100; t_exp[3] = v4(32'h8000_0001, 32'hFF00_FF00, 32'h63, 32'hFFFF_FFFC);
        t_op[4] = 3'b101; t_exp[4] = v4(32'h1, 32'h1, 32'h0, 32'h1);
        t_op[5] = 3'b110; t_exp[5] = v4(32'h0, 32'hF0F0_0000, 32'h200, 32'hFFFF_FFF8);
        for (int i = 0; i < 6; i++) begin
            drive(t_op[i], ta, tb, 1, 0, 0, t_exp[i], tb);
            tick();
        end

        // Forwarding: scalar ADD leaves 9 in ALU_ResultM. The next ops read it, ResultW or RD1_E.
        drive(3'b000, v4(11, 22, 33, 4), v4(1, 2, 3, 5), 0, 0, 0, v4(0, 0, 0, 9), v4(1, 2, 3, 5));
        tick();
        ForwardA_E = 2'b10; ForwardB_E = 2'b01; ResultW = v4(7, 7, 7, 3);
        drive(3'b001, v4(5, 5, 5, 32'h55), v4(5, 5, 5, 32'h66), 0, 0, 0, v4(0, 0, 0, 6), v4(7, 7, 7, 3));
        tick();
        ForwardA_E = 2'b11; ForwardB_E = 2'b00;
        drive(3'b001, v4(0, 0, 0, 20), v4(0, 0, 0, 8), 0, 0, 0, v4(0, 0, 0, 12), v4(0, 0, 0, 8));
        tick();
        ForwardA_E = 2'b00; ForwardB_E = 2'b10;
        drive(3'b000, v4(1, 1, 1, 1), v4(32'hAA, 32'hBB, 32'hCC, 32'hDD), 1, 0, 0,
              v4(1, 1, 1, 13), v4(0, 0, 0, 12));
        tick();
        ForwardA_E = 2'b00; ForwardB_E = 2'b00; ResultW = '0;

        // Multi-cycle MUL. The forward selects change after the first cycle.
        drive(3'b111, v4(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF),
              v4(2, 2, 2, 2), 1, 0, 0,
              v4(32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE), v4(2, 2, 2, 2));
        #1;
        n = 0;
        while (stall_e === 1'b1 && n < 16) begin
            n++;
            tick();
            check("mul_bubble_valid_m", valid_m, 0);
            if (n == 1) begin
                ForwardA_E = 2'b01; ForwardB_E = 2'b01; ResultW = v4(3, 3, 3, 3);
            end
        end
        check("mul_stall_cycles", n, 3);
        tick();
        idle_inputs();

        // Branch taken, then the same case flushed, then upper-lane mismatch with PC wrap.
        drive(3'b001, v4(7, 7, 7, 7), v4(7, 7, 7, 7), 1, 0, 32'h20, '0, v4(7, 7, 7, 7));
        BranchE = 1; PCE = 32'h100;
        #1 check("br_pcsrc", PCSrcE, 1);
        check("br_target", PCTargetE, 32'h120);
        tick();
        flush_e = 1; Imm_Ext_E = 32'hFFFF_FFF0;
        #1 check("br_flush_pcsrc", PCSrcE, 0);
        check("br_neg_target", PCTargetE, 32'hF0);
        tick();
        check("br_flush_valid_m", valid_m, 0);
        check("br_flush_regwrite_m", RegWriteM, 0);
        flush_e = 0;
        drive(3'b001, v4(1, 7, 7, 7), v4(0, 7, 7, 7), 1, 0, 32'h20, v4(1, 0, 0, 0), v4(0, 7, 7, 7));
        BranchE = 1; PCE = 32'hFFFF_FFF0;
        #1 check("br_upper_lane_pcsrc", PCSrcE, 0);
        check("br_wrap_target", PCTargetE, 32'h10);
        tick();
        idle_inputs();

        // Reset during the second MUL cycle aborts the op.
        valid_e = 1; ALUControlE = 3'b111; is_vectorial = 1; RegWriteE = 1;
        RD1_E = v4(3, 3, 3, 3); RD2_E = v4(5, 5, 5, 5); RD_E = 6'h2A; PCPlus4E = 32'h2000;
        tick();
        check("rst_mul_running", stall_e, 1);
        rst = 1; valid_e = 0;
        tick();
        check_m_zero("mul_rst");
        rst = 0;
        idle_inputs();
        drive(3'b000, v4(1, 2, 3, 4), v4(1, 1, 1, 1), 1, 0, 0, v4(2, 3, 4, 5), v4(1, 1, 1, 1));
        tick();
        idle_inputs();
        for (int i = 0; i < 6; i++) tick();

        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
